reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file for the pipelined core, replacing the single-cycle 2R1W file. It adds three things: a write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a multi-cycle synchronous clear sequencer. It sits between decode, which reads operands and issues destinations, and writeback, which writes results.

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; NUM_REGS = 2**ADDR_W.
- NUM_RD, 2: number of read ports.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero, never written and never pending.

Ports:
- Clk  in  1: single clock; all state changes on rising edge.
- Rst_n  in  1: reset, asynchronous and active-low.
- ReadRegister  in  NUM_RD*ADDR_W: packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- DataRead  out  NUM_RD*DATA_W: packed read data, combinational.
- Busy  out  NUM_RD: per-port flag; operand not yet available.
- RegWrite  in  1: write enable.
- WriteRegister  in  ADDR_W: write address.
- WriteData  in  DATA_W: write data.
- Issue  in  1: mark IssueRegister as having an in-flight producer.
- IssueRegister  in  ADDR_W: destination being issued.
- Flush  in  1: drop all pending bits, for pipeline flush.
- Clear  in  1: start the sweep that zeroes all registers.
- Ready  out  1: high when IDLE; low during the sweep.

## Operation
- Storage: NUM_REGS x DATA_W flops. A pending[NUM_REGS] bit vector holds the scoreboard.
- Read, port i, address a, priority order:
  - If sweeping, DataRead = 0.
  - Else if ZERO_REG and a==0, DataRead = 0.
  - Else if RegWrite and WriteRegister==a, DataRead = WriteData (bypass).
  - Else DataRead = reg[a].
- Busy[i] = pending[a] & ~(RegWrite & WriteRegister==a) & Ready. Busy is always 0 for a==0 when ZERO_REG.
- Write: at the edge, when RegWrite & Ready & ~(ZERO_REG & WriteRegister==0), reg[WriteRegister] <= WriteData and pending[WriteRegister] <= 0.
- Issue: at the edge, when Issue & Ready & ~(ZERO_REG & IssueRegister==0), pending[IssueRegister] <= 1.
- Issue and write to the same register in the same cycle: Issue wins, so pending stays 1 for the new producer. Data is still written.
- Flush clears all pending bits. Flush overrides Issue in the same cycle. Writes still commit.
- FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when Clear. At that edge, idx <= 0 and all pending bits are cleared.
  - In SWEEP, each cycle sets reg[idx] <= 0 and idx <= idx+1.
  - SWEEP -> IDLE on the edge where idx == NUM_REGS-1 is cleared.
  - In SWEEP, RegWrite, Issue, Flush and Clear are ignored.
- idx is an ADDR_W-bit counter. The terminal compare is against the all-ones value, with no wrap into a second pass.

## Timing
- Reset (Rst_n low, asynchronous):
  - Every register and every pending bit is 0, state is IDLE, idx is 0.
  - Outputs: Ready=1, Busy=0, DataRead=0.
  - Reset mid-sweep aborts the sweep immediately. The sweep does not resume after release.
- Read latency is 0 cycles, combinational from the address, with bypass in the same cycle.
- A write is visible through storage from the cycle after the edge.
- Issue makes Busy visible from the cycle after the edge.
- Clear asserted at edge T:
  - Ready is low from T+1 through T+NUM_REGS.
  - Ready is high again at T+NUM_REGS+1, with all registers 0.
  - The sweep takes exactly NUM_REGS cycles, independent of ZERO_REG.
- No handshake back-pressure. Upstream must hold RegWrite and Issue while Ready is low, or accept that they are dropped.

## Structure
- Package regfile_pkg holds:
  - typedef enum {IDLE, SWEEP} rf_state_t;
  - the localparam function for NUM_REGS;
  - the reset constants.
- Sub-module reg_scoreboard holds the pending vector together with its Issue, write-clear, Flush and sweep-clear logic and the Busy generation. It is instantiated once.
- The top level holds storage, read muxes, bypass and the FSM.

## Test plan
- Reset, then write reg 5 = 0xDEADBEEF. The next cycle, read port 0 addr 5 -> 0xDEADBEEF. In the write cycle itself, port 1 addr 5 -> 0xDEADBEEF via bypass.
- Write reg 0 = 0x1234 with ZERO_REG=1 -> reads of reg 0 return 0 and Busy stays 0. Issue to reg 0 -> no pending bit set.
- Issue reg 7 -> Busy=1 on the next cycle. Write reg 7 = 0x55 -> Busy=0 in the write cycle and DataRead=0x55. Repeat with Issue and write of reg 7 in the same cycle -> Busy=1 afterwards.
- Issue regs 3 and 9, then Flush -> both Busy=0 on the next cycle. Flush together with Issue of reg 4 -> reg 4 is not pending.
- Fill all registers with non-zero values, then pulse Clear:
  - Ready is low for exactly 32 cycles and DataRead=0 throughout.
  - A write of 0xAA to reg 2 during the sweep is dropped.
  - Afterwards, all registers read 0.
- Start Clear, then assert Rst_n low at sweep cycle 10 -> immediately Ready=1 and all registers 0. After release, a write and read of reg 1 works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Holds the sequencer state type, the register-count helper and reset values.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_t;

  function automatic int num_regs_f(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam rf_state_t STATE_RST = IDLE;
  localparam logic      READY_RST = 1'b1;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register set by Issue, cleared by
// the matching write, by Flush, or wholesale when a clear sweep starts.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ready,
  input  logic                     sweep_start,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_register,
  input  logic                     issue,
  input  logic [ADDR_W-1:0]        issue_register,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] read_register,
  output logic [NUM_RD-1:0]        busy
);

  localparam int NUM_REGS = num_regs_f(ADDR_W);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                wr_en;
  logic                issue_en;

  assign wr_en    = reg_write & ready & ~((ZERO_REG != 0) && (write_register == '0));
  assign issue_en = issue & ready & ~((ZERO_REG != 0) && (issue_register == '0));

  // Write clears first so a same-cycle Issue re-arms the bit for the new producer.
  always_comb begin
    pending_d = pending_q;
    if (sweep_start) begin
      pending_d = '0;
    end else begin
      if (wr_en) pending_d[write_register] = 1'b0;
      if (ready && flush) begin
        pending_d = '0;
      end else if (issue_en) begin
        pending_d[issue_register] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_busy
      logic [ADDR_W-1:0] addr;
      assign addr     = read_register[gi*ADDR_W +: ADDR_W];
      assign busy[gi] = ready & pending_q[addr]
                      & ~(reg_write && (write_register == addr))
                      & ~((ZERO_REG != 0) && (addr == '0));
    end
  endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass, pending-write scoreboard
// and a one-register-per-cycle synchronous clear sweep.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
  output logic [NUM_RD*DATA_W-1:0] DataRead,
  output logic [NUM_RD-1:0]        Busy,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegister,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     Issue,
  input  logic [ADDR_W-1:0]        IssueRegister,
  input  logic                     Flush,
  input  logic                     Clear,
  output logic                     Ready
);

  localparam int NUM_REGS = num_regs_f(ADDR_W);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;
  logic              sweep_start;

  assign wr_en       = RegWrite & ready_q & ~((ZERO_REG != 0) && (WriteRegister == '0));
  assign sweep_start = (state_q == IDLE) && Clear;
  assign Ready       = ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    regs_d = regs_q;
    if (state_q == SWEEP)  regs_d[idx_q]         = '0;
    else if (wr_en)        regs_d[WriteRegister] = WriteData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= STATE_RST;
      idx_q   <= '0;
      ready_q <= READY_RST;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      regs_q  <= regs_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = ReadRegister[gi*ADDR_W +: ADDR_W];
      assign DataRead[gi*DATA_W +: DATA_W] =
          !ready_q                               ? '0 :
          ((ZERO_REG != 0) && (addr == '0))      ? '0 :
          (RegWrite && (WriteRegister == addr))  ? WriteData :
                                                   regs_q[addr];
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk           (Clk),
    .rst_n         (Rst_n),
    .ready         (ready_q),
    .sweep_start   (sweep_start),
    .reg_write     (RegWrite),
    .write_register(WriteRegister),
    .issue         (Issue),
    .issue_register(IssueRegister),
    .flush         (Flush),
    .read_register (ReadRegister),
    .busy          (Busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized bench for reg_file_sb against a behavioural model
// of register contents, pending bits and the clear sweep.
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [9:0]  ReadRegister;
  logic [63:0] DataRead;
  logic [1:0]  Busy;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Issue;
  logic [4:0]  IssueRegister;
  logic        Flush;
  logic        Clear;
  logic        Ready;

  reg_file_sb dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReadRegister(ReadRegister), .DataRead(DataRead),
    .Busy(Busy), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .Issue(Issue), .IssueRegister(IssueRegister),
    .Flush(Flush), .Clear(Clear), .Ready(Ready)
  );

  always #5 Clk = ~Clk;

  int passes = 0;
  int total  = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_sweeping;
  int          m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_sweeping = 1'b0;
    m_idx      = 0;
  endtask

  function automatic logic [31:0] exp_data(input int a);
    if (m_sweeping) return '0;
    if (a == 0) return '0;
    if (RegWrite && WriteRegister == a[4:0]) return WriteData;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (m_sweeping || a == 0) return 1'b0;
    if (RegWrite && WriteRegister == a[4:0]) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    if (m_sweeping) begin
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == 32) m_sweeping = 1'b0;
    end else begin
      if (RegWrite && WriteRegister != 0) begin
        m_mem[WriteRegister]  = WriteData;
        m_pend[WriteRegister] = 1'b0;
      end
      if (Clear) begin
        m_sweeping = 1'b1;
        m_idx      = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (Flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (Issue && IssueRegister != 0) begin
        m_pend[IssueRegister] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int a;
    chk("ready", {31'd0, Ready}, {31'd0, !m_sweeping});
    for (int p = 0; p < 2; p++) begin
      a = int'(ReadRegister[p*5 +: 5]);
      chk("data", DataRead[p*32 +: 32], exp_data(a));
      chk("busy", {31'd0, Busy[p]}, {31'd0, exp_busy(a)});
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    check_outputs();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1);
    ReadRegister = {p1[4:0], p0[4:0]};
  endtask

  task automatic idle_inputs();
    RegWrite = 0; WriteRegister = 0; WriteData = 0;
    Issue = 0; IssueRegister = 0; Flush = 0; Clear = 0;
  endtask

  int low_cnt;

  initial begin
    Rst_n = 1'b0;
    idle_inputs();
    set_rd(5, 7);
    model_reset();
    #12;
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_data0", DataRead[31:0], 32'd0);
    chk("rst_data1", DataRead[63:32], 32'd0);
    chk("rst_busy", {30'd0, Busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // write with same-cycle bypass, then storage read
    set_rd(0, 5); RegWrite = 1; WriteRegister = 5; WriteData = 32'hDEADBEEF;
    #1 chk("bypass_p1", DataRead[63:32], 32'hDEADBEEF);
    tick();
    idle_inputs(); set_rd(5, 0);
    #1 chk("stored_p0", DataRead[31:0], 32'hDEADBEEF);
    tick();

    // register zero
    RegWrite = 1; WriteRegister = 0; WriteData = 32'h1234; set_rd(0, 0);
    #1 chk("zero_bypass", DataRead[31:0], 32'd0);
    tick();
    idle_inputs(); Issue = 1; IssueRegister = 0;
    tick();
    idle_inputs();
    #1 chk("zero_data", DataRead[31:0], 32'd0);
    chk("zero_busy", {31'd0, Busy[0]}, 32'd0);
    tick();

    // issue / write on reg 7
    Issue = 1; IssueRegister = 7;
    tick();
    idle_inputs(); set_rd(7, 7);
    #1 chk("issue_busy", {31'd0, Busy[0]}, 32'd1);
    tick();
    RegWrite = 1; WriteRegister = 7; WriteData = 32'h55;
    #1 chk("wr_busy", {31'd0, Busy[1]}, 32'd0);
    chk("wr_data", DataRead[63:32], 32'h55);
    tick();
    idle_inputs();
    #1 chk("after_wr_busy", {31'd0, Busy[0]}, 32'd0);
    tick();
    Issue = 1; IssueRegister = 7; RegWrite = 1; WriteRegister = 7; WriteData = 32'h66;
    tick();
    idle_inputs();
    #1 chk("iss_wins_busy", {31'd0, Busy[0]}, 32'd1);
    chk("iss_wins_data", DataRead[31:0], 32'h66);
    tick();

    // flush
    Issue = 1; IssueRegister = 3; tick();
    IssueRegister = 9; tick();
    idle_inputs(); Flush = 1; tick();
    idle_inputs(); set_rd(3, 9);
    #1 chk("flush_busy", {30'd0, Busy}, 32'd0);
    tick();
    Flush = 1; Issue = 1; IssueRegister = 4; tick();
    idle_inputs(); set_rd(4, 4);
    #1 chk("flush_over_issue", {30'd0, Busy}, 32'd0);
    tick();

    // fill then clear sweep
    for (int a = 0; a < 32; a++) begin
      RegWrite = 1; WriteRegister = a[4:0]; WriteData = 32'h01010101 * (a + 1);
      set_rd(a, (a + 1) % 32);
      tick();
    end
    idle_inputs(); Clear = 1;
    tick();
    idle_inputs();
    low_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        RegWrite = 1; WriteRegister = 2; WriteData = 32'hAA; set_rd(2, 2);
      end else begin
        RegWrite = 0; set_rd(int'($urandom_range(31)), int'($urandom_range(31)));
      end
      #1;
      if (Ready !== 1'b0) break;
      low_cnt++;
      chk("sweep_data", DataRead[31:0], 32'd0);
      tick();
    end
    idle_inputs();
    chk("ready_low_cycles", low_cnt, 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1 chk("cleared", DataRead[31:0] | DataRead[63:32], 32'd0);
      tick();
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      RegWrite      = $urandom_range(1);
      WriteRegister = 5'($urandom_range(31));
      WriteData     = $urandom;
      Issue         = $urandom_range(1);
      IssueRegister = 5'($urandom_range(31));
      Flush         = ($urandom_range(15) == 0);
      Clear         = ($urandom_range(59) == 0);
      if (($urandom_range(3)) == 0) set_rd(WriteRegister, int'($urandom_range(31)));
      else set_rd(int'($urandom_range(31)), int'(IssueRegister));
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 40 && m_sweeping; k++) tick();

    // reset in the middle of a sweep
    Clear = 1; tick();
    idle_inputs();
    repeat (10) tick();
    #2 Rst_n = 1'b0;
    #1 chk("midsweep_ready", {31'd0, Ready}, 32'd1);
    model_reset();
    set_rd(31, 17);
    #1 chk("midsweep_data", DataRead[31:0] | DataRead[63:32], 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      set_rd(a, a);
      tick();
    end
    RegWrite = 1; WriteRegister = 1; WriteData = 32'h13572468;
    tick();
    idle_inputs(); set_rd(1, 1);
    #1 chk("post_rst_rw", DataRead[31:0], 32'h13572468);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
